mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 79 +++++++
 tb/tb_mem_read_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Two-port round-robin read arbiter in front of a fixed-latency memory.
// A tag pipeline routes each returning word back to the port that issued it.
module mem_read_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [2:0]        inflight
);

  localparam int unsigned CNT_W = 3;

  logic               last_grant;   // 1 = port 1 was granted last
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_p;
  logic [CNT_W-1:0]   cnt;
  logic               rv0_raw;
  logic               rv1_raw;

  // Ties go to the port that did not win last time; everything is held at 0 in reset.
  always_comb begin
    gnt0        = rst_n & req0 & (~req1 | last_grant);
    gnt1        = rst_n & req1 & (~req0 | ~last_grant);
    mem_read_en = gnt0 | gnt1;
    if (!rst_n)    mem_addr = '0;
    else if (gnt1) mem_addr = addr1;
    else           mem_addr = addr0;
  end

  // Return path driven by the oldest tag stage.
  always_comb begin
    rv0_raw  = tag_v[LATENCY-1] & ~tag_p[LATENCY-1];
    rv1_raw  = tag_v[LATENCY-1] &  tag_p[LATENCY-1];
    rvalid0  = rst_n & rv0_raw;
    rvalid1  = rst_n & rv1_raw;
    rdata0   = rvalid0 ? mem_q : '0;
    rdata1   = rvalid1 ? mem_q : '0;
    inflight = rst_n ? cnt : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      tag_v      <= '0;
      tag_p      <= '0;
      cnt        <= '0;
    end else begin
      if (mem_read_en) last_grant <= gnt1;
      tag_v[0] <= mem_read_en;
      tag_p[0] <= gnt1;
      for (int i = 1; i < int'(LATENCY); i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
      // A grant and a return in the same cycle cancel out.
      case ({mem_read_en, rvalid0 | rvalid1})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: stimulus pushes expected returns into
// per-port queues, a negedge monitor pops and compares them.
module tb_mem_read_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_read_en;
  logic [31:0] rdata0, rdata1, mem_addr, mem_q;
  logic [2:0]  inflight;

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_q(mem_q),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] bram [64];
  logic [31:0] mq   [LAT];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word = byte address / 4, data appears LAT cycles after the strobe.
  always @(posedge clk) begin
    mq[0] <= mem_read_en ? bram[mem_addr[7:2]] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) mq[i] <= mq[i-1];
  end
  assign mem_q = mq[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every returned word must match the oldest outstanding read of that port.
  always @(negedge clk) begin
    exp_t e;
    chk("rvalid_onehot", 64'(rvalid0 & rvalid1), 64'd0);
    chk("inflight_max", 64'(inflight > 3'(LAT)), 64'd0);
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", 64'(rvalid0), 64'd0);
      else begin
        e = q0.pop_front();
        chk("rdata0", 64'(rdata0), 64'(e.data));
        chk("rvalid0_cycle", 64'(cyc), 64'(e.due));
      end
    end else chk("rdata0_idle", 64'(rdata0), 64'd0);
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 64'(rvalid1), 64'd0);
      else begin
        e = q1.pop_front();
        chk("rdata1", 64'(rdata1), 64'(e.data));
        chk("rvalid1_cycle", 64'(cyc), 64'(e.due));
      end
    end else chk("rdata1_idle", 64'(rdata1), 64'd0);
  end

  // One cycle of stimulus with its hand-computed grant and inflight expectation.
  task automatic step(input logic r0, input logic [31:0] a0, input logic r1,
                      input logic [31:0] a1, input logic eg0, input logic eg1,
                      input int einf);
    exp_t e;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    @(negedge clk);
    chk("gnt0", 64'(gnt0), 64'(eg0));
    chk("gnt1", 64'(gnt1), 64'(eg1));
    chk("mem_read_en", 64'(mem_read_en), 64'(eg0 | eg1));
    chk("mem_addr", 64'(mem_addr), 64'(eg1 ? a1 : a0));
    chk("inflight", 64'(inflight), 64'(einf));
    if (eg0) begin e.data = bram[a0[7:2]]; e.due = cyc + LAT; q0.push_back(e); end
    if (eg1) begin e.data = bram[a1[7:2]]; e.due = cyc + LAT; q1.push_back(e); end
    @(posedge clk); #1;
  endtask

  // One reset cycle with requests held high; all outputs must read zero.
  task automatic reset_cycle();
    rst_n = 1'b0; req0 = 1'b1; addr0 = 32'h44; req1 = 1'b1; addr1 = 32'h48;
    q0.delete(); q1.delete();
    @(negedge clk);
    chk("rst_gnt0", 64'(gnt0), 64'd0);
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    chk("rst_mem_read_en", 64'(mem_read_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rvalid0", 64'(rvalid0), 64'd0);
    chk("rst_rvalid1", 64'(rvalid1), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) bram[i] = 32'h1000 + 32'(i) * 32'h0101_0101;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    @(posedge clk); #1;
    reset_cycle();
    reset_cycle();

    // Single read, granted in the first cycle out of reset.
    step(1, 32'h10, 0, 32'h0, 1, 0, 0);
    step(0, 32'h0,  0, 32'h0, 0, 0, 1);
    step(0, 32'h0,  0, 32'h0, 0, 0, 1);
    step(0, 32'h0,  0, 32'h0, 0, 0, 0);

    // Two reads in flight, then reset: neither may return.
    step(0, 32'h0,  1, 32'h20, 0, 1, 0);
    step(1, 32'h24, 0, 32'h0,  1, 0, 1);
    reset_cycle();

    // Tie: port 0 wins first after reset, then strict alternation.
    step(1, 32'h0, 1, 32'h40, 1, 0, 0);
    step(1, 32'h0, 1, 32'h40, 0, 1, 1);
    step(1, 32'h0, 1, 32'h40, 1, 0, 2);
    step(1, 32'h0, 1, 32'h40, 0, 1, 2);
    step(0, 32'h0, 0, 32'h0,  0, 0, 2);
    step(0, 32'h0, 0, 32'h0,  0, 0, 1);
    step(0, 32'h0, 0, 32'h0,  0, 0, 0);

    // Back-to-back stream on port 1.
    for (int i = 0; i < 8; i++) step(0, 32'h0, 1, 32'(4 * i), 0, 1, (i < 2) ? i : 2);
    step(0, 32'h0, 0, 32'h0, 0, 0, 2);
    step(0, 32'h0, 0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 32'h0, 0, 0, 0);

    // Port 1 loses a tie and drops its request: no grant, no return.
    step(1, 32'h8, 1, 32'h30, 1, 0, 0);
    step(0, 32'h0, 0, 32'h0,  0, 0, 1);
    step(0, 32'h0, 0, 32'h0,  0, 0, 1);
    step(0, 32'h0, 0, 32'h0,  0, 0, 0);
    step(0, 32'h0, 0, 32'h0,  0, 0, 0);

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
